// File: rtl/ex_div_ctrl_pkg.sv
// Shared types for the EX-stage iterative divider: op encoding, FSM states, request payload.
`ifndef DIV_PKG_SV
`define DIV_PKG_SV
package div_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = $clog2(XLEN);
  localparam int unsigned RD_W  = 5;

  typedef enum logic [1:0] {
    DIV  = 2'd0,
    DIVU = 2'd1,
    REM  = 2'd2,
    REMU = 2'd3
  } divop_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

  typedef struct packed {
    logic [RD_W-1:0] rd;
    logic [XLEN-1:0] opr_a;
    logic [XLEN-1:0] opr_b;
    divop_t          divop;
  } div_req_t;

  // Two's-complement negate when neg is set; used for |x| and final sign fix-up.
  function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic neg);
    return neg ? (~v + XLEN'(1)) : v;
  endfunction

endpackage
`endif

// File: rtl/ex_div_ctrl_if.sv
// EX-stage <-> divider request/result bundle.
interface ex_div_ctrl_if;
  logic                      start_i;
  div_pkg::divop_t           divop_i;
  logic [div_pkg::XLEN-1:0]  opr_a_i;
  logic [div_pkg::XLEN-1:0]  opr_b_i;
  logic [div_pkg::RD_W-1:0]  rd_i;
  logic                      flush_i;
  logic                      stall_o;
  logic                      res_valid_o;
  logic [div_pkg::XLEN-1:0]  res_o;
  logic [div_pkg::RD_W-1:0]  res_rd_o;

  modport master (
    output start_i, divop_i, opr_a_i, opr_b_i, rd_i, flush_i,
    input  stall_o, res_valid_o, res_o, res_rd_o
  );

  modport slave (
    input  start_i, divop_i, opr_a_i, opr_b_i, rd_i, flush_i,
    output stall_o, res_valid_o, res_o, res_rd_o
  );
endinterface

// File: rtl/ex_div_ctrl_step.sv
// One restoring-division iteration; quotient bits shift into the dividend register LSB.
module ex_div_ctrl_step
  import div_pkg::*;
(
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] dvd_i,
  input  logic [XLEN-1:0] dvs_i,
  output logic [XLEN-1:0] rem_o,
  output logic [XLEN-1:0] dvd_o,
  output logic            qbit_o
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] trial;

  // Shifted remainder needs XLEN+1 bits when the divisor has its MSB set.
  always_comb begin
    shifted = {rem_i, dvd_i[XLEN-1]};
    trial   = shifted - {1'b0, dvs_i};
    qbit_o  = ~trial[XLEN];
    rem_o   = qbit_o ? trial[XLEN-1:0] : shifted[XLEN-1:0];
    dvd_o   = {dvd_i[XLEN-2:0], qbit_o};
  end

endmodule

// File: rtl/ex_div_ctrl.sv
// RV32M DIV/DIVU/REM/REMU sequencer: stalls EX while a restoring divider runs one bit per cycle.
module ex_div_ctrl
  import div_pkg::*;
(
  input  logic         clk,
  input  logic         arst_n,
  ex_div_ctrl_if.slave dif
);

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  div_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  rem_q, rem_d;
  logic [XLEN-1:0]  dvd_q, dvd_d;
  logic [XLEN-1:0]  dvs_q, dvs_d;
  divop_t           op_q, op_d;
  logic [RD_W-1:0]  rd_q, rd_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic [XLEN-1:0]  res_q, res_d;
  logic [RD_W-1:0]  res_rd_q, res_rd_d;
  logic             valid_q, valid_d;
  logic             stall_c;

  div_req_t         req;
  logic             req_signed;
  logic             req_rem;
  logic [XLEN-1:0]  step_rem;
  logic [XLEN-1:0]  step_dvd;
  logic             step_qbit;

  always_comb begin
    req.rd    = dif.rd_i;
    req.opr_a = dif.opr_a_i;
    req.opr_b = dif.opr_b_i;
    req.divop = dif.divop_i;
    req_signed = (req.divop == DIV) || (req.divop == REM);
    req_rem    = (req.divop == REM) || (req.divop == REMU);
  end

  ex_div_ctrl_step u_step (
    .rem_i  (rem_q),
    .dvd_i  (dvd_q),
    .dvs_i  (dvs_q),
    .rem_o  (step_rem),
    .dvd_o  (step_dvd),
    .qbit_o (step_qbit)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    op_d     = op_q;
    rd_d     = rd_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    res_d    = res_q;
    res_rd_d = res_rd_q;
    valid_d  = 1'b0;
    stall_c  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (dif.start_i) begin
          stall_c = 1'b1;
          op_d    = req.divop;
          rd_d    = req.rd;
          rem_d   = '0;
          dvd_d   = cond_neg(req.opr_a, req_signed & req.opr_a[XLEN-1]);
          dvs_d   = cond_neg(req.opr_b, req_signed & req.opr_b[XLEN-1]);
          qneg_d  = req_signed & (req.opr_a[XLEN-1] ^ req.opr_b[XLEN-1]);
          rneg_d  = req_signed & req.opr_a[XLEN-1];
          // Special cases resolve immediately without iterating.
          if (req.opr_b == '0) begin
            res_d    = req_rem ? req.opr_a : '1;
            res_rd_d = req.rd;
            valid_d  = 1'b1;
            state_d  = DONE;
          end else if (req_signed && (req.opr_a == INT_MIN) && (req.opr_b == '1)) begin
            res_d    = req_rem ? '0 : INT_MIN;
            res_rd_d = req.rd;
            valid_d  = 1'b1;
            state_d  = DONE;
          end else begin
            cnt_d   = CNT_W'(XLEN - 1);
            state_d = CALC;
          end
        end
      end
      CALC: begin
        stall_c = 1'b1;
        rem_d   = step_rem;
        dvd_d   = step_dvd;
        if (cnt_q == '0) begin
          res_d    = op_q[1] ? cond_neg(step_rem, rneg_q) : cond_neg(step_dvd, qneg_q);
          res_rd_d = rd_q;
          valid_d  = 1'b1;
          state_d  = DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A flush kills whatever is in flight and leaves the last result untouched.
    if (dif.flush_i) begin
      state_d  = IDLE;
      stall_c  = 1'b0;
      valid_d  = 1'b0;
      res_d    = res_q;
      res_rd_d = res_rd_q;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      op_q     <= DIV;
      rd_q     <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      res_q    <= '0;
      res_rd_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      res_q    <= res_d;
      res_rd_q <= res_rd_d;
      valid_q  <= valid_d;
    end
  end

  // Stall must drop while reset is asserted even if EX still presents a request.
  assign dif.stall_o     = stall_c & arst_n;
  assign dif.res_valid_o = valid_q;
  assign dif.res_o       = res_q;
  assign dif.res_rd_o    = res_rd_q;

endmodule

// File: tb/tb_ex_div_ctrl.sv
// Directed bench for ex_div_ctrl: normal ops, special cases, flush and mid-op reset.
module tb_ex_div_ctrl;
  import div_pkg::*;

  logic clk;
  logic arst_n;
  int   n_checks;
  int   n_fail;

  ex_div_ctrl_if dif ();

  ex_div_ctrl dut (
    .clk    (clk),
    .arst_n (arst_n),
    .dif    (dif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one op, hold start until the result strobe, then check result, rd, latency and stalls.
  task automatic run_op(input string tag, input divop_t op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp_res, input int exp_lat);
    int cyc;
    int stalls;
    logic got;
    @(posedge clk);
    #1;
    dif.divop_i = op;
    dif.opr_a_i = a;
    dif.opr_b_i = b;
    dif.rd_i    = rd;
    dif.start_i = 1'b1;
    cyc = 0;
    stalls = 0;
    got = 1'b0;
    while (!got && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (dif.res_valid_o) got = 1'b1;
      else if (dif.stall_o) stalls++;
    end
    check({tag, "_valid"}, 32'(got), 32'd1);
    check({tag, "_lat"}, 32'(cyc), 32'(exp_lat));
    check({tag, "_res"}, dif.res_o, exp_res);
    check({tag, "_rd"}, 32'(dif.res_rd_o), 32'(rd));
    check({tag, "_stalls"}, 32'(stalls), 32'(exp_lat - 1));
    check({tag, "_done_stall"}, 32'(dif.stall_o), 32'd0);
    @(posedge clk);
    #1;
    dif.start_i = 1'b0;
    @(negedge clk);
    check({tag, "_strobe_drop"}, 32'(dif.res_valid_o), 32'd0);
    check({tag, "_hold"}, dif.res_o, exp_res);
  endtask

  initial begin
    int   seen_valid;
    int   seen_stall;
    n_checks = 0;
    n_fail   = 0;
    arst_n      = 1'b0;
    dif.start_i = 1'b0;
    dif.divop_i = DIV;
    dif.opr_a_i = '0;
    dif.opr_b_i = '0;
    dif.rd_i    = '0;
    dif.flush_i = 1'b0;
    #3;
    check("rst_stall", 32'(dif.stall_o), 32'd0);
    check("rst_valid", 32'(dif.res_valid_o), 32'd0);
    check("rst_res", dif.res_o, 32'd0);
    check("rst_rd", 32'(dif.res_rd_o), 32'd0);
    @(negedge clk);
    arst_n = 1'b1;

    run_op("divu_100_7", DIVU, 32'd100, 32'd7, 5'd3, 32'd14, 34);
    run_op("rem_m100_7", REM, 32'hFFFF_FF9C, 32'd7, 5'd4, 32'hFFFF_FFFE, 34);
    run_op("div_m100_7", DIV, 32'hFFFF_FF9C, 32'd7, 5'd5, 32'hFFFF_FFF2, 34);
    run_op("div_by0", DIV, 32'd5, 32'd0, 5'd6, 32'hFFFF_FFFF, 2);
    run_op("remu_by0", REMU, 32'd5, 32'd0, 5'd7, 32'd5, 2);
    run_op("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 32'h8000_0000, 2);
    run_op("rem_ovf", REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 32'd0, 2);
    run_op("divu_bigdvs", DIVU, 32'hFFFF_FFFF, 32'h8000_0000, 5'd10, 32'd1, 34);
    run_op("remu_bigdvs", REMU, 32'hFFFF_FFFF, 32'h8000_0000, 5'd11, 32'h7FFF_FFFF, 34);
    run_op("rem_7_m2", REM, 32'd7, 32'hFFFF_FFFE, 5'd12, 32'd1, 34);

    // Flush during CALC cycle 10.
    @(posedge clk);
    #1;
    dif.divop_i = DIVU;
    dif.opr_a_i = 32'd1000;
    dif.opr_b_i = 32'd3;
    dif.rd_i    = 5'd13;
    dif.start_i = 1'b1;
    repeat (11) @(negedge clk);
    check("flush_pre_stall", 32'(dif.stall_o), 32'd1);
    dif.flush_i = 1'b1;
    dif.start_i = 1'b0;
    #1;
    check("flush_stall", 32'(dif.stall_o), 32'd0);
    @(posedge clk);
    #1;
    dif.flush_i = 1'b0;
    seen_valid = 0;
    seen_stall = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (dif.res_valid_o) seen_valid++;
      if (dif.stall_o) seen_stall++;
    end
    check("flush_no_valid", 32'(seen_valid), 32'd0);
    check("flush_idle_stall", 32'(seen_stall), 32'd0);
    check("flush_res_kept", dif.res_o, 32'd1);
    run_op("divu_9_3", DIVU, 32'd9, 32'd3, 5'd14, 32'd3, 34);

    // Asynchronous reset during CALC cycle 5.
    @(posedge clk);
    #1;
    dif.divop_i = DIVU;
    dif.opr_a_i = 32'd50;
    dif.opr_b_i = 32'd5;
    dif.rd_i    = 5'd15;
    dif.start_i = 1'b1;
    repeat (6) @(negedge clk);
    #2;
    arst_n = 1'b0;
    #1;
    check("arst_stall", 32'(dif.stall_o), 32'd0);
    check("arst_valid", 32'(dif.res_valid_o), 32'd0);
    check("arst_res", dif.res_o, 32'd0);
    check("arst_rd", 32'(dif.res_rd_o), 32'd0);
    dif.start_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    arst_n = 1'b1;
    seen_valid = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (dif.res_valid_o) seen_valid++;
    end
    check("arst_no_partial", 32'(seen_valid), 32'd0);
    run_op("divu_max_1", DIVU, 32'hFFFF_FFFF, 32'd1, 5'd16, 32'hFFFF_FFFF, 34);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_div_ctrl.md
Name: ex_div_ctrl

Overview:
Iterative RV32M divide/remainder unit with its sequencing FSM, sitting beside the ALU in the EX stage.
- Accepts a DIV/DIVU/REM/REMU request from the EX stage and stalls the pipeline while it runs.
- Runs a one-bit-per-cycle restoring divider and returns the result with rd for the EX-stage output struct.
- Resolves RISC-V special cases (divide-by-zero, signed overflow) without iterating.

Parameters:
XLEN, 32, operand/result width; the iteration count equals XLEN.
CNT_W, $clog2(XLEN), width of the iteration counter; derived, do not override.

Ports:
clk  in  1  core clock
arst_n  in  1  asynchronous active-low reset
start_i  in  1  EX holds a valid divide-class op; held high and stable while stall_o=1
divop_i  in  2  div_pkg::divop_t: DIV=0, DIVU=1, REM=2, REMU=3
opr_a_i  in  XLEN  dividend (rs1)
opr_b_i  in  XLEN  divisor (rs2)
rd_i  in  5  destination register
flush_i  in  1  EX flush from branch/CFU redirect; kills the op in flight
stall_o  out  1  freeze IF/ID/EX this cycle
res_valid_o  out  1  single-cycle result strobe
res_o  out  XLEN  quotient or remainder
res_rd_o  out  5  rd of the result

Behaviour:
- One clock: clk. Reset is asynchronous, active-low, on arst_n. During reset: state=IDLE, counter=0, all datapath registers 0; stall_o=0, res_valid_o=0, res_o=0, res_rd_o=0.
- States: IDLE, CALC, DONE.
- IDLE:
  - start_i=1 and flush_i=0: latch divop, rd, |a|, |b|, quotient sign (a[31]^b[31] for DIV), remainder sign (a[31] for REM). Unsigned ops take no absolute value.
  - If the op is a special case, go to DONE. Otherwise set counter=XLEN-1 and go to CALC.
- CALC: one restoring step per cycle.
  - Shift {rem, dividend} left by 1.
  - Trial-subtract the divisor from rem; if the result is non-negative, keep it and set the quotient LSB to 1.
  - When counter=0, go to DONE; otherwise decrement the counter.
- DONE:
  - res_valid_o=1; res_o = signed-corrected quotient (DIV/DIVU) or remainder (REM/REMU); res_rd_o = latched rd.
  - Always return to IDLE the next cycle.
  - start_i sampled in DONE is ignored; it is the same instruction, which retires this cycle.
- stall_o = (IDLE & start_i & ~flush_i) | CALC. This is combinational from state and inputs. stall_o=0 in DONE so EX advances with the result.
- Latency: normal op takes XLEN+2 cycles from first start_i to res_valid_o (34 for XLEN=32). Special case takes 2 cycles.
- Special cases, per the RISC-V spec:
  - b=0: quotient = all ones (DIV and DIVU); remainder = a.
  - Signed overflow (a=0x80000000, b=0xFFFFFFFF, DIV/REM): quotient = 0x80000000; remainder = 0.
- flush_i=1 in any state: go to IDLE next cycle; res_valid_o stays 0 for the killed op; stall_o=0 that cycle.
- res_o and res_rd_o hold their last values outside DONE; consumers qualify them with res_valid_o.
- Back-to-back divides: the second op's start_i is sampled in the IDLE cycle after DONE. Issue rate is one divide per XLEN+2 cycles.
- Asserting arst_n low mid-CALC aborts immediately to the reset values; no partial result is emitted.

Decomposition:
- New package div_pkg.svh, guarded and includable like the other pkg headers. It holds:
  - divop_t: 2-bit enum.
  - div_state_t: enum IDLE/CALC/DONE.
  - Struct div_req_t {rd, opr_a, opr_b, divop}.
- ex_stage_in_t gains a divop_t field and a div-select bit in a follow-up change.
- One natural sub-module: div_step. It is the combinational single restoring iteration: in {rem, dvd, dvs}, out {rem', dvd', qbit}.
- The FSM, counter and sign correction stay in ex_div_ctrl.

Test Plan:
- DIVU: a=100, b=7 -> stall_o high 33 cycles; res_valid_o at cycle 34; res_o=14, res_rd_o as driven.
- REM: a=-100 (0xFFFFFF9C), b=7 -> res_o=-2 (0xFFFFFFFE). DIV with the same operands -> res_o=-14 (0xFFFFFFF2).
- Divide by zero: DIV a=5, b=0 -> res_o=0xFFFFFFFF at cycle 2. REMU a=5, b=0 -> res_o=5. Neither enters CALC.
- Overflow: DIV a=0x80000000, b=0xFFFFFFFF -> res_o=0x80000000. REM with the same operands -> res_o=0. Both in 2 cycles.
- flush_i pulsed at CALC cycle 10 -> IDLE next cycle, stall_o=0, no res_valid_o. A new DIVU 9/3 then returns 3.
- arst_n low at CALC cycle 5 -> all outputs 0 asynchronously. After release, DIVU 0xFFFFFFFF/1 -> 0xFFFFFFFF.
